// File: rtl/hq2x_pattern_gen.sv
// HQ2x neighbour-difference pattern generator: one 3x3 window in, 8-bit "differs" mask out.
// Build option HQ2X_PATTERN_PAR_EN: eight difference units, single CMP cycle; default is one shared unit over 8 cycles.
module hq2x_pattern_gen (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [14:0]  in_center,
  input  logic [119:0] in_nbr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_pattern,
  output logic [14:0]  out_center,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the producer
  // holds data steady while valid is high and ready is low.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [14:0]    r_center;
  logic [119:0]   r_nbr;
  logic [7:0]     r_pattern;
  logic [14:0]    w_nbr [8];

  // YUV-like threshold test on 6-bit channel deltas; returns 1 when the pixels differ.
  function automatic logic f_differs(input logic [14:0] c, input logic [14:0] n);
    logic signed [5:0] r, g, b;
    logic signed [6:0] t, u;
    logic signed [7:0] y, v;
    r = {1'b0, c[4:0]}   - {1'b0, n[4:0]};
    g = {1'b0, c[9:5]}   - {1'b0, n[9:5]};
    b = {1'b0, c[14:10]} - {1'b0, n[14:10]};
    t = {r[5], r} + {b[5], b};
    u = {r[5], r} - {b[5], b};
    y = {t[6], t} + {{2{g[5]}}, g};
    v = {g[5], g, 1'b0} - {t[6], t};
    f_differs = !((y >= -8'sd24) && (y <= 8'sd23) &&
                  (u >= -7'sd4)  && (u <= 7'sd3)  &&
                  (v >= -8'sd6)  && (v <= 8'sd5));
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_nbr
    assign w_nbr[gi] = r_nbr[15*gi +: 15];
  end

`ifdef HQ2X_PATTERN_PAR_EN
  logic [7:0] w_par;
  for (genvar gi = 0; gi < 8; gi++) begin : g_diff
    assign w_par[gi] = f_differs(r_center, w_nbr[gi]);
  end
`else
  logic [2:0] r_index;
  logic       w_bit;
  assign w_bit = f_differs(r_center, w_nbr[r_index]);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ST_CMP;
      end
      ST_CMP: begin
`ifdef HQ2X_PATTERN_PAR_EN
        w_next_state = ST_DONE;
`else
        if (r_index == 3'd7) w_next_state = ST_DONE;
`endif
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_center  <= '0;
      r_nbr     <= '0;
      r_pattern <= '0;
`ifndef HQ2X_PATTERN_PAR_EN
      r_index   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_center  <= in_center;
            r_nbr     <= in_nbr;
            r_pattern <= '0;
`ifndef HQ2X_PATTERN_PAR_EN
            r_index   <= '0;
`endif
          end
        end
        ST_CMP: begin
`ifdef HQ2X_PATTERN_PAR_EN
          r_pattern <= w_par;
`else
          r_pattern[r_index] <= w_bit;
          r_index            <= r_index + 3'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_pattern = r_pattern;
  assign out_center  = r_center;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_hq2x_pattern_gen.sv
// Directed bench for hq2x_pattern_gen: hand-computed patterns, latency, stall, reset and streaming cases.
module tb_hq2x_pattern_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [14:0]  in_center;
  logic [119:0] in_nbr;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_pattern;
  logic [14:0]  out_center;
  logic [1:0]   dbg_state;

`ifdef HQ2X_PATTERN_PAR_EN
  localparam int LAT_EDGES = 2;
  localparam int PERIOD    = 3;
`else
  localparam int LAT_EDGES = 9;
  localparam int PERIOD    = 10;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [22:0] exp_q[$];

  hq2x_pattern_gen dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_center(in_center), .in_nbr(in_nbr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pattern(out_pattern), .out_center(out_center),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] fill(input logic [14:0] px);
    fill = {8{px}};
  endfunction

  function automatic logic [119:0] put(input logic [119:0] nb, input int idx, input logic [14:0] px);
    logic [119:0] r;
    r = nb;
    r[15*idx +: 15] = px;
    put = r;
  endfunction

  task automatic send(input logic [14:0] c, input logic [119:0] nb, input logic [7:0] p, input bit push);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_center = c;
    in_nbr    = nb;
    if (push) exp_q.push_back({c, p});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts that edge as edge 1.
  task automatic collect(input string tag, input int hold);
    int edges = 1;
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (out_valid || edges >= 40) break;
      @(posedge clk);
      edges++;
    end
    check({tag, "_lat"}, edges, LAT_EDGES);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, "_pat"}, {24'd0, out_pattern}, {24'd0, e[7:0]});
    check({tag, "_ctr"}, {17'd0, out_center}, {17'd0, e[22:8]});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_pat"}, {24'd0, out_pattern}, {24'd0, e[7:0]});
      check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run_window(input string tag, input logic [14:0] c, input logic [119:0] nb,
                            input logic [7:0] p, input int hold);
    send(c, nb, p, 1'b1);
    collect(tag, hold);
  endtask

  initial begin
    logic [14:0]  wc [3];
    logic [119:0] wn [3];
    logic [7:0]   wp [3];
    int           acc [3];
    int           k, nout;
    bit           saw_valid;
    logic [22:0]  e;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_center = '0; in_nbr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pat", {24'd0, out_pattern}, 32'h00);
    check("rst_ctr", {17'd0, out_center}, 32'h0000);

    run_window("zero", 15'h0000, fill(15'h0000), 8'h00, 0);
    run_window("u_m4", 15'h0000, put(fill(15'h0000), 3, 15'h0004), 8'h00, 0);
    run_window("u_m5", 15'h0000, put(fill(15'h0000), 3, 15'h0005), 8'h08, 0);
    run_window("y_m24", 15'h0000, fill(15'h2108), 8'h00, 0);
    run_window("y_m27", 15'h0000, fill(15'h2529), 8'hFF, 0);
    run_window("u_p4_p3", 15'h0004, put(put(fill(15'h0004), 1, 15'h0000), 4, 15'h0001), 8'h02, 0);
    run_window("y_p24_p23", 15'h2108, put(put(fill(15'h2108), 2, 15'h0000), 5, 15'h0001), 8'h04, 0);
    run_window("v_p5_p6", 15'h0061, put(put(fill(15'h0061), 0, 15'h0000), 6, 15'h0001), 8'h40, 0);
    run_window("white_ctr", 15'h7FFF, put(fill(15'h7FFF), 0, 15'h0000), 8'h01, 0);
    run_window("v_m24_stall", 15'h0000, put(fill(15'h0000), 7, 15'h0180), 8'h80, 5);

    // Reset while a window is in flight: it must vanish without an output.
    send(15'h0000, fill(15'h2529), 8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_pat", {24'd0, out_pattern}, 32'h00);
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_out", {31'd0, saw_valid}, 32'd0);
    run_window("post_rst", 15'h0000, put(fill(15'h0000), 3, 15'h0005), 8'h08, 0);

    // Streaming: in_valid never drops; junk is offered whenever the block is busy.
    wc[0] = 15'h0000; wn[0] = put(fill(15'h0000), 1, 15'h2529); wp[0] = 8'h02;
    wc[1] = 15'h2529; wn[1] = put(fill(15'h2529), 5, 15'h0000); wp[1] = 8'h20;
    wc[2] = 15'h0000; wn[2] = fill(15'h0005);                    wp[2] = 8'hFF;
    k = 0; nout = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("stream_pat", {24'd0, out_pattern}, {24'd0, e[7:0]});
        check("stream_ctr", {17'd0, out_center}, {17'd0, e[22:8]});
        nout++;
      end
      if (k < 3) begin
        in_valid = 1'b1;
        if (in_ready) begin
          in_center = wc[k];
          in_nbr    = wn[k];
          exp_q.push_back({wc[k], wp[k]});
          acc[k] = cyc;
          k++;
        end else begin
          in_center = 15'h7C00;
          in_nbr    = fill(15'h03FF);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("stream_accepts", k, 3);
    check("stream_outputs", nout, 3);
    check("stream_q_empty", exp_q.size(), 0);
    check("stream_period01", acc[1] - acc[0], PERIOD);
    check("stream_period12", acc[2] - acc[1], PERIOD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
